// File: rtl/dallan_cozum_denetleyici.sv
// gshare branch-predictor sequencer: table clear sweep after reset, in-order queue of
// outstanding predictions, speculative GHR, resolution compare, table updates and flush/redirect.
module dallan_cozum_denetleyici #(
  parameter int IDX_W    = 4,
  parameter int DERINLIK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             getir_gecerli,
  input  logic [31:0]      getir_ps,
  input  logic             getir_tahmin,
  input  logic [31:0]      getir_tahmin_ps,
  output logic             getir_durdur,
  input  logic             yurut_gecerli,
  input  logic [31:0]      yurut_ps,
  input  logic             yurut_dallan,
  input  logic [31:0]      yurut_dallan_ps,
  output logic [IDX_W-1:0] ggy,
  output logic             guncelle_gecerli,
  output logic [IDX_W-1:0] guncelle_indeks,
  output logic             guncelle_dallan,
  output logic             tablo_sifirla,
  output logic             temizle,
  output logic [31:0]      yonlendir_ps,
  output logic [31:0]      yanlis_tahmin_sayaci,
  output logic             hata
);

  localparam int PTR_W = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               dir_q, dir_d;
  logic               upd_q, upd_d;
  logic [31:0]        redir_q, redir_d;
  logic [IDX_W-1:0]   ggy_q, ggy_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mis_q, mis_d;
  logic               hata_q, hata_d;

  logic [31:0]        ps_mem   [DERINLIK];
  logic               t_mem    [DERINLIK];
  logic [31:0]        tps_mem  [DERINLIK];
  logic [IDX_W-1:0]   snap_mem [DERINLIK];

  logic               full;
  logic               push;
  logic               pop;
  logic               res_ok;
  logic               mispredict;
  logic [31:0]        head_ps;
  logic               head_t;
  logic [31:0]        head_tps;
  logic [IDX_W-1:0]   head_snap;

  assign head_ps   = ps_mem[rd_q];
  assign head_t    = t_mem[rd_q];
  assign head_tps  = tps_mem[rd_q];
  assign head_snap = snap_mem[rd_q];
  assign full      = (count_q == CNT_W'(DERINLIK));

  assign res_ok     = (state_q == ST_RUN) && yurut_gecerli && (count_q != '0) &&
                      (head_ps == yurut_ps);
  // A taken/taken pair still mispredicts when the targets disagree.
  assign mispredict = res_ok && ((head_t != yurut_dallan) ||
                                 (head_t && yurut_dallan && (head_tps != yurut_dallan_ps)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    upd_d   = 1'b0;
    redir_d = redir_q;
    ggy_d   = ggy_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    mis_d   = mis_q;
    hata_d  = hata_q;
    push    = 1'b0;
    pop     = 1'b0;

    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (yurut_gecerli && !res_ok) begin
          hata_d = 1'b1;
        end
        if (res_ok) begin
          upd_d = 1'b1;
          idx_d = head_ps[IDX_W-1:0] ^ head_snap;
          dir_d = yurut_dallan;
        end
        if (mispredict) begin
          state_d = ST_RECOVER;
          wr_d    = '0;
          rd_d    = '0;
          count_d = '0;
          ggy_d   = {head_snap[IDX_W-2:0], yurut_dallan};
          redir_d = yurut_dallan ? yurut_dallan_ps : (yurut_ps + 32'd4);
          if (mis_q != 32'hFFFF_FFFF) begin
            mis_d = mis_q + 32'd1;
          end
        end else begin
          pop  = res_ok;
          push = getir_gecerli && !full;
          if (pop) begin
            rd_d = rd_q + 1'b1;
          end
          if (push) begin
            wr_d  = wr_q + 1'b1;
            ggy_d = {ggy_q[IDX_W-2:0], getir_tahmin};
          end
          count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
      end

      ST_RECOVER: begin
        state_d = ST_RUN;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      upd_q   <= 1'b0;
      redir_q <= '0;
      ggy_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      mis_q   <= '0;
      hata_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
      redir_q <= redir_d;
      ggy_q   <= ggy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mis_q   <= mis_d;
      hata_q  <= hata_d;
    end
  end

  // Queue payload needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ps_mem[wr_q]   <= getir_ps;
      t_mem[wr_q]    <= getir_tahmin;
      tps_mem[wr_q]  <= getir_tahmin_ps;
      snap_mem[wr_q] <= ggy_q;
    end
  end

  assign getir_durdur         = (state_q != ST_RUN) || full;
  assign tablo_sifirla        = (state_q == ST_INIT);
  assign temizle              = (state_q == ST_RECOVER);
  assign ggy                  = ggy_q;
  assign guncelle_gecerli     = upd_q;
  assign guncelle_indeks      = idx_q;
  assign guncelle_dallan      = dir_q;
  assign yonlendir_ps         = redir_q;
  assign yanlis_tahmin_sayaci = mis_q;
  assign hata                 = hata_q;

endmodule

// File: tb/tb_dallan_cozum_denetleyici.sv
// Directed bench for dallan_cozum_denetleyici: INIT sweep, vector table in RUN,
// and reset during RECOVER.
module tb_dallan_cozum_denetleyici;

  logic        clk = 1'b0;
  logic        rst;
  logic        getir_gecerli;
  logic [31:0] getir_ps;
  logic        getir_tahmin;
  logic [31:0] getir_tahmin_ps;
  logic        getir_durdur;
  logic        yurut_gecerli;
  logic [31:0] yurut_ps;
  logic        yurut_dallan;
  logic [31:0] yurut_dallan_ps;
  logic [3:0]  ggy;
  logic        guncelle_gecerli;
  logic [3:0]  guncelle_indeks;
  logic        guncelle_dallan;
  logic        tablo_sifirla;
  logic        temizle;
  logic [31:0] yonlendir_ps;
  logic [31:0] yanlis_tahmin_sayaci;
  logic        hata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dallan_cozum_denetleyici #(.IDX_W(4), .DERINLIK(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .getir_gecerli        (getir_gecerli),
    .getir_ps             (getir_ps),
    .getir_tahmin         (getir_tahmin),
    .getir_tahmin_ps      (getir_tahmin_ps),
    .getir_durdur         (getir_durdur),
    .yurut_gecerli        (yurut_gecerli),
    .yurut_ps             (yurut_ps),
    .yurut_dallan         (yurut_dallan),
    .yurut_dallan_ps      (yurut_dallan_ps),
    .ggy                  (ggy),
    .guncelle_gecerli     (guncelle_gecerli),
    .guncelle_indeks      (guncelle_indeks),
    .guncelle_dallan      (guncelle_dallan),
    .tablo_sifirla        (tablo_sifirla),
    .temizle              (temizle),
    .yonlendir_ps         (yonlendir_ps),
    .yanlis_tahmin_sayaci (yanlis_tahmin_sayaci),
    .hata                 (hata)
  );

  typedef struct {
    logic        gv;
    logic [31:0] gps;
    logic        gt;
    logic [31:0] gtps;
    logic        yv;
    logic [31:0] yps;
    logic        yd;
    logic [31:0] ydps;
    logic        e_durdur;
    logic [3:0]  e_ggy;
    logic        e_upd;
    logic [3:0]  e_idx;
    logic        e_dir;
    logic        e_tem;
    logic [31:0] e_redir;
    logic [31:0] e_cnt;
    logic        e_hata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic gv, input logic [31:0] gps, input logic gt,
                       input logic [31:0] gtps, input logic yv, input logic [31:0] yps,
                       input logic yd, input logic [31:0] ydps);
    getir_gecerli   = gv;
    getir_ps        = gps;
    getir_tahmin    = gt;
    getir_tahmin_ps = gtps;
    yurut_gecerli   = yv;
    yurut_ps        = yps;
    yurut_dallan    = yd;
    yurut_dallan_ps = ydps;
  endtask

  task automatic addv(input logic gv, input logic [31:0] gps, input logic gt,
                      input logic [31:0] gtps, input logic yv, input logic [31:0] yps,
                      input logic yd, input logic [31:0] ydps,
                      input logic e_durdur, input logic [3:0] e_ggy, input logic e_upd,
                      input logic [3:0] e_idx, input logic e_dir, input logic e_tem,
                      input logic [31:0] e_redir, input logic [31:0] e_cnt, input logic e_hata);
    vec_t v;
    v.gv = gv; v.gps = gps; v.gt = gt; v.gtps = gtps;
    v.yv = yv; v.yps = yps; v.yd = yd; v.ydps = ydps;
    v.e_durdur = e_durdur; v.e_ggy = e_ggy; v.e_upd = e_upd; v.e_idx = e_idx;
    v.e_dir = e_dir; v.e_tem = e_tem; v.e_redir = e_redir; v.e_cnt = e_cnt;
    v.e_hata = e_hata;
    vecs.push_back(v);
  endtask

  initial begin
    // Columns: push(gv,ps,t,tps) resolve(yv,ps,d,dps) | durdur ggy upd idx dir temizle redir cnt hata
    addv(1,32'h100,0,32'h0,   0,32'h0,0,32'h0,          0,4'h0,0,4'h0,0,0,32'h0,  0,0); // 0
    addv(0,32'h0,0,32'h0,     1,32'h100,0,32'h0,        0,4'h0,1,4'h0,0,0,32'h0,  0,0); // 1
    addv(0,32'h0,0,32'h0,     0,32'h0,0,32'h0,          0,4'h0,0,4'h0,0,0,32'h0,  0,0); // 2
    addv(1,32'h104,0,32'h0,   0,32'h0,0,32'h0,          0,4'h0,0,4'h0,0,0,32'h0,  0,0); // 3
    addv(1,32'h108,1,32'h180, 1,32'h104,1,32'h140,      1,4'h1,1,4'h4,1,1,32'h140,1,0); // 4
    addv(0,32'h0,0,32'h0,     0,32'h0,0,32'h0,          0,4'h1,0,4'h0,0,0,32'h140,1,0); // 5
    addv(1,32'h20C,1,32'h200, 0,32'h0,0,32'h0,          0,4'h3,0,4'h0,0,0,32'h140,1,0); // 6
    addv(0,32'h0,0,32'h0,     1,32'h20C,1,32'h204,      1,4'h3,1,4'hD,1,1,32'h204,2,0); // 7
    addv(0,32'h0,0,32'h0,     0,32'h0,0,32'h0,          0,4'h3,0,4'h0,0,0,32'h204,2,0); // 8
    addv(1,32'hFFFFFFFC,1,32'h10, 0,32'h0,0,32'h0,      0,4'h7,0,4'h0,0,0,32'h204,2,0); // 9
    addv(0,32'h0,0,32'h0,     1,32'hFFFFFFFC,0,32'h0,   1,4'h6,1,4'hF,0,1,32'h0,  3,0); // 10
    addv(0,32'h0,0,32'h0,     0,32'h0,0,32'h0,          0,4'h6,0,4'h0,0,0,32'h0,  3,0); // 11
    addv(1,32'h400,1,32'h500, 0,32'h0,0,32'h0,          0,4'hD,0,4'h0,0,0,32'h0,  3,0); // 12
    addv(1,32'h404,0,32'h0,   0,32'h0,0,32'h0,          0,4'hA,0,4'h0,0,0,32'h0,  3,0); // 13
    addv(1,32'h408,1,32'h600, 0,32'h0,0,32'h0,          0,4'h5,0,4'h0,0,0,32'h0,  3,0); // 14
    addv(1,32'h40C,1,32'h700, 0,32'h0,0,32'h0,          1,4'hB,0,4'h0,0,0,32'h0,  3,0); // 15
    addv(1,32'h410,0,32'h0,   0,32'h0,0,32'h0,          1,4'hB,0,4'h0,0,0,32'h0,  3,0); // 16
    addv(1,32'h410,0,32'h0,   1,32'h400,1,32'h500,      0,4'hB,1,4'h6,1,0,32'h0,  3,0); // 17
    addv(1,32'h410,0,32'h0,   1,32'h404,0,32'h0,        0,4'h6,1,4'h9,0,0,32'h0,  3,0); // 18
    addv(1,32'h414,1,32'h800, 0,32'h0,0,32'h0,          1,4'hD,0,4'h0,0,0,32'h0,  3,0); // 19
    addv(0,32'h0,0,32'h0,     1,32'h408,1,32'h600,      0,4'hD,1,4'h2,1,0,32'h0,  3,0); // 20
    addv(0,32'h0,0,32'h0,     1,32'h40C,1,32'h700,      0,4'hD,1,4'h9,1,0,32'h0,  3,0); // 21
    addv(0,32'h0,0,32'h0,     1,32'h410,0,32'h0,        0,4'hD,1,4'hB,0,0,32'h0,  3,0); // 22
    addv(0,32'h0,0,32'h0,     1,32'h414,1,32'h800,      0,4'hD,1,4'h2,1,0,32'h0,  3,0); // 23
    addv(0,32'h0,0,32'h0,     1,32'h414,1,32'h800,      0,4'hD,0,4'h0,0,0,32'h0,  3,1); // 24
    addv(1,32'h100,0,32'h0,   0,32'h0,0,32'h0,          0,4'hA,0,4'h0,0,0,32'h0,  3,1); // 25
    addv(0,32'h0,0,32'h0,     1,32'h300,0,32'h0,        0,4'hA,0,4'h0,0,0,32'h0,  3,1); // 26
    addv(0,32'h0,0,32'h0,     1,32'h100,0,32'h0,        0,4'hA,1,4'hD,0,0,32'h0,  3,1); // 27

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;

    chk("reset tablo_sifirla", 32'(tablo_sifirla), 1);
    chk("reset getir_durdur", 32'(getir_durdur), 1);
    chk("reset temizle", 32'(temizle), 0);
    chk("reset guncelle_gecerli", 32'(guncelle_gecerli), 0);
    chk("reset guncelle_dallan", 32'(guncelle_dallan), 0);
    chk("reset ggy", 32'(ggy), 0);
    chk("reset yonlendir_ps", yonlendir_ps, 0);
    chk("reset sayac", yanlis_tahmin_sayaci, 0);
    chk("reset hata", 32'(hata), 0);

    // Execute activity during the sweep must be ignored.
    drive(0, 0, 0, 0, 1, 32'h1234, 1, 32'h40);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("init indeks %0d", i), 32'(guncelle_indeks), 32'(i));
      chk($sformatf("init tablo_sifirla %0d", i), 32'(tablo_sifirla), 1);
      chk($sformatf("init getir_durdur %0d", i), 32'(getir_durdur), 1);
      tick();
    end
    chk("run getir_durdur", 32'(getir_durdur), 0);
    chk("run tablo_sifirla", 32'(tablo_sifirla), 0);
    chk("run ggy", 32'(ggy), 0);
    chk("init ignores execute hata", 32'(hata), 0);
    chk("init ignores execute upd", 32'(guncelle_gecerli), 0);

    foreach (vecs[k]) begin
      drive(vecs[k].gv, vecs[k].gps, vecs[k].gt, vecs[k].gtps,
            vecs[k].yv, vecs[k].yps, vecs[k].yd, vecs[k].ydps);
      tick();
      chk($sformatf("vec%0d getir_durdur", k), 32'(getir_durdur), 32'(vecs[k].e_durdur));
      chk($sformatf("vec%0d ggy", k), 32'(ggy), 32'(vecs[k].e_ggy));
      chk($sformatf("vec%0d guncelle_gecerli", k), 32'(guncelle_gecerli), 32'(vecs[k].e_upd));
      if (vecs[k].e_upd) begin
        chk($sformatf("vec%0d guncelle_indeks", k), 32'(guncelle_indeks), 32'(vecs[k].e_idx));
        chk($sformatf("vec%0d guncelle_dallan", k), 32'(guncelle_dallan), 32'(vecs[k].e_dir));
      end
      chk($sformatf("vec%0d temizle", k), 32'(temizle), 32'(vecs[k].e_tem));
      chk($sformatf("vec%0d yonlendir_ps", k), yonlendir_ps, vecs[k].e_redir);
      chk($sformatf("vec%0d sayac", k), yanlis_tahmin_sayaci, vecs[k].e_cnt);
      chk($sformatf("vec%0d hata", k), 32'(hata), 32'(vecs[k].e_hata));
    end

    // Reset while in RECOVER: must abort the flush and restart the sweep at index 0.
    drive(1, 32'h500, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h500, 1, 32'h40);
    tick();
    chk("recover temizle", 32'(temizle), 1);
    chk("recover yonlendir_ps", yonlendir_ps, 32'h40);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    chk("rst in recover temizle", 32'(temizle), 0);
    chk("rst in recover tablo_sifirla", 32'(tablo_sifirla), 1);
    chk("rst in recover indeks", 32'(guncelle_indeks), 0);
    chk("rst in recover getir_durdur", 32'(getir_durdur), 1);
    chk("rst in recover hata", 32'(hata), 0);
    chk("rst in recover sayac", yanlis_tahmin_sayaci, 0);
    chk("rst in recover yonlendir_ps", yonlendir_ps, 0);
    chk("rst in recover guncelle_gecerli", 32'(guncelle_gecerli), 0);
    tick();
    chk("restart indeks 1", 32'(guncelle_indeks), 1);
    chk("restart tablo_sifirla", 32'(tablo_sifirla), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dallan_cozum_denetleyici.md
Name: dallan_cozum_denetleyici

Overview:
- Sequences the gshare branch predictor between fetch and execute.
- Holds an in-order queue of outstanding predictions and keeps the speculative global history register (GHR).
- Compares each execute-stage resolution with its recorded prediction. Issues predictor-table update commands and, on a mispredict, a one-cycle pipeline flush with a redirect PC.
- After reset, sweeps the predictor table to its reset state before allowing fetch.

Parameters:
- IDX_W, 4: predictor index width and GHR width; table has 2^IDX_W entries.
- DERINLIK, 4: outstanding-prediction queue depth (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- getir_gecerli  in  1  fetch presents a predicted branch this cycle
- getir_ps  in  32  PC of the fetched branch
- getir_tahmin  in  1  predicted taken
- getir_tahmin_ps  in  32  predicted target (don't-care when not taken)
- getir_durdur  out  1  fetch must hold; push is ignored while high
- yurut_gecerli  in  1  execute resolves the oldest outstanding branch
- yurut_ps  in  32  PC of the resolved branch
- yurut_dallan  in  1  actual taken
- yurut_dallan_ps  in  32  actual target
- ggy  out  IDX_W  speculative GHR, driven to the predictor
- guncelle_gecerli  out  1  table update strobe
- guncelle_indeks  out  IDX_W  table index to update or clear
- guncelle_dallan  out  1  update direction (1 = increment, 0 = decrement)
- tablo_sifirla  out  1  clear entry guncelle_indeks to strongly-not-taken
- temizle  out  1  flush fetch/decode; one-cycle pulse
- yonlendir_ps  out  32  redirect PC; valid while temizle is high
- yanlis_tahmin_sayaci  out  32  mispredict count, saturating
- hata  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state to INIT, queue empty, ggy=0, counter=0, hata=0
  - temizle=0, guncelle_gecerli=0, yonlendir_ps=0, guncelle_dallan=0
  - guncelle_indeks=0, tablo_sifirla=1, getir_durdur=1
- Reset asserted during any state, including RECOVER, aborts that state immediately.
- States are INIT, RUN and RECOVER.
- INIT:
  - Lasts 2^IDX_W cycles.
  - tablo_sifirla=1; guncelle_indeks counts 0..2^IDX_W-1, one per cycle; getir_durdur=1.
  - The execute inputs are ignored.
  - After the last index, the state becomes RUN with tablo_sifirla=0.
- RUN:
  - getir_durdur = queue full.
  - Push occurs when getir_gecerli && !getir_durdur. It stores the entry {getir_ps, getir_tahmin, getir_tahmin_ps, snap=ggy}. ggy then becomes {ggy[IDX_W-2:0], getir_tahmin}.
- Resolve (RUN, yurut_gecerli=1):
  - If the queue is empty or the head PC differs from yurut_ps: set hata=1 and change nothing else.
  - Otherwise pop the head.
  - One cycle later: guncelle_gecerli=1, guncelle_indeks = head.ps[IDX_W-1:0] XOR head.snap, guncelle_dallan = yurut_dallan.
- Mispredict is defined as head.tahmin != yurut_dallan, OR both taken and head.tahmin_ps != yurut_dallan_ps.
- On mispredict, detected in cycle N:
  - At the N edge: queue cleared, ggy = {head.snap[IDX_W-2:0], yurut_dallan}, counter incremented unless it is 0xFFFFFFFF, state becomes RECOVER.
  - A push offered in cycle N is discarded; ggy does not include it.
  - Cycle N+1 (RECOVER): temizle=1, getir_durdur=1, yonlendir_ps = yurut_dallan ? yurut_dallan_ps : yurut_ps+4 (registered), guncelle_gecerli=1 for the resolving branch. The execute inputs are ignored.
  - Cycle N+2: state returns to RUN.
- Simultaneous push and correct resolve in the same cycle: both take effect and occupancy is unchanged. A resolve with a full queue plus a push is impossible because getir_durdur is high.
- Queue pointers wrap modulo DERINLIK. Occupancy is tracked with a count of width log2(DERINLIK)+1.
- yonlendir_ps holds its value outside temizle. guncelle_gecerli is low except one cycle after a successful resolve.
- PC+4 arithmetic wraps modulo 2^32.

Test Plan:
- Reset, then idle -> tablo_sifirla=1 and guncelle_indeks 0..15 over 16 cycles with getir_durdur=1. On cycle 17: getir_durdur=0, tablo_sifirla=0, ggy=0.
- Push ps=0x100 with tahmin=0, then resolve ps=0x100 with dallan=0 -> no temizle. Next cycle: guncelle_gecerli=1, guncelle_indeks=0x0, guncelle_dallan=0. Counter stays 0.
- Push ps=0x104 with tahmin=0 (ggy=0). Next push ps=0x108 with tahmin=1 in the same cycle that 0x104 resolves dallan=1, ps_target=0x140 -> next cycle: temizle=1, yonlendir_ps=0x140, guncelle_indeks=0x4. Then: ggy=0x1, queue empty, counter=1, the 0x108 push dropped.
- Both predicted and actual taken, but target 0x200 vs actual 0x204 -> mispredict, yonlendir_ps=0x204. Taken predicted, not taken actual at ps=0xFFFFFFFC -> yonlendir_ps=0x00000000.
- Push 4 branches without resolving -> getir_durdur=1 after the 4th, and a 5th push is ignored. Resolve one -> getir_durdur drops; ggy reflects exactly 4 predicted bits.
- Resolve with an empty queue, or ps=0x300 against head 0x100 -> hata=1 and stays 1 with the queue unchanged. Assert rst during RECOVER -> temizle=0 and INIT restarts at index 0.
